// File: rtl/ascon_aead128_axi_slave.sv
// ascon_aead128_axi_slave
// AXI4-Lite register front end for an Ascon-AEAD128 core.
// Holds the key, nonce, AD and DIN operand registers. Captures the DOUT and TAG
// results from the core. Exposes CONTROL (start/mode) and STATUS.
// Optional build macro: ASCON_AXI_SLVERR_EN. When it is defined, unmapped
// accesses and writes to read-only words answer SLVERR instead of OKAY.
module ascon_aead128_axi_slave (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [6:0]   awaddr,
  input  logic [2:0]   awprot,
  input  logic         awvalid,
  output logic         awready,
  input  logic [31:0]  wdata,
  input  logic [3:0]   wstrb,
  input  logic         wvalid,
  output logic         wready,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready,
  input  logic [6:0]   araddr,
  input  logic [2:0]   arprot,
  input  logic         arvalid,
  output logic         arready,
  output logic [31:0]  rdata,
  output logic [1:0]   rresp,
  output logic         rvalid,
  input  logic         rready,
  output logic [127:0] key,
  output logic [127:0] nonce,
  output logic [127:0] ad,
  output logic [127:0] din,
  output logic         ad_valid,
  output logic         din_valid,
  output logic         start,
  output logic         mode,
  input  logic [127:0] dout,
  input  logic [127:0] tag,
  input  logic         dout_valid,
  input  logic         tag_valid,
  input  logic         core_ready
);

  localparam logic [4:0] IDX_AD3     = 5'd11;
  localparam logic [4:0] IDX_DIN3    = 5'd15;
  localparam logic [4:0] IDX_DOUT0   = 5'd16;
  localparam logic [4:0] IDX_DOUT3   = 5'd19;
  localparam logic [4:0] IDX_CONTROL = 5'd24;
  localparam logic [4:0] IDX_UNMAP0  = 5'd26;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge a new word into an old one, byte lane by byte lane, under a strobe.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Select one 32-bit word of a 128-bit register (word 0 = bits 31:0).
  function automatic logic [31:0] word_of(input logic [127:0] vec,
                                          input logic [1:0]   sel);
    return vec[{sel, 5'd0} +: 32];
  endfunction

  // Registered state
  logic         aw_held_q, aw_held_d;
  logic [4:0]   aw_idx_q, aw_idx_d;
  logic         w_held_q, w_held_d;
  logic [31:0]  w_data_q, w_data_d;
  logic [3:0]   w_strb_q, w_strb_d;
  logic         awready_q, awready_d;
  logic         wready_q, wready_d;
  logic         bvalid_q, bvalid_d;
  logic [1:0]   bresp_q, bresp_d;
  logic         arready_q, arready_d;
  logic         rvalid_q, rvalid_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [1:0]   rresp_q, rresp_d;
  logic [127:0] key_q, key_d;
  logic [127:0] nonce_q, nonce_d;
  logic [127:0] ad_q, ad_d;
  logic [127:0] din_q, din_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] tag_q, tag_d;
  logic         start_q, start_d;
  logic         mode_q, mode_d;
  logic         end_aead_q, end_aead_d;
  logic         dout_avail_q, dout_avail_d;
  logic         ad_valid_q, ad_valid_d;
  logic         din_valid_q, din_valid_d;

  // Combinational helpers
  logic         aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic         commit_s, wr_en_s, ctrl_wr_s, clr_end_s;
  logic [4:0]   ar_idx_s;
  logic [31:0]  rd_word_s;
  logic [31:0]  status_s;
  logic [1:0]   wr_resp_s, rd_resp_s;
  logic         unused_ok_s;

  // Protection bits and byte offsets carry no meaning for this register file.
  assign unused_ok_s = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  assign ar_idx_s = araddr[6:2];
  assign status_s = {29'd0, dout_avail_q, end_aead_q, core_ready};

  // Response codes: only the error-reporting build flags bad accesses.
  always_comb begin
`ifdef ASCON_AXI_SLVERR_EN
    if ((aw_idx_q >= IDX_DOUT0) && (aw_idx_q != IDX_CONTROL)) begin
      wr_resp_s = RESP_SLVERR;
    end else begin
      wr_resp_s = RESP_OKAY;
    end
    if (ar_idx_s >= IDX_UNMAP0) begin
      rd_resp_s = RESP_SLVERR;
    end else begin
      rd_resp_s = RESP_OKAY;
    end
`else
    wr_resp_s = RESP_OKAY;
    rd_resp_s = RESP_OKAY;
`endif
  end

  // Read mux built from the current (pre-write) register contents.
  always_comb begin
    rd_word_s = 32'd0;
    case (ar_idx_s[4:2])
      3'd0: rd_word_s = word_of(key_q, ar_idx_s[1:0]);
      3'd1: rd_word_s = word_of(nonce_q, ar_idx_s[1:0]);
      3'd2: rd_word_s = word_of(ad_q, ar_idx_s[1:0]);
      3'd3: rd_word_s = word_of(din_q, ar_idx_s[1:0]);
      3'd4: rd_word_s = word_of(dout_q, ar_idx_s[1:0]);
      3'd5: rd_word_s = word_of(tag_q, ar_idx_s[1:0]);
      3'd6: begin
        case (ar_idx_s[1:0])
          2'd0:    rd_word_s = {30'd0, mode_q, start_q};
          2'd1:    rd_word_s = status_s;
          default: rd_word_s = 32'd0;
        endcase
      end
      default: rd_word_s = 32'd0;
    endcase
  end

  // AXI channel handshakes, write commit and next-state for every flop.
  always_comb begin
    aw_hs_s  = awvalid && awready_q;
    w_hs_s   = wvalid && wready_q;
    b_hs_s   = bvalid_q && bready;
    ar_hs_s  = arvalid && arready_q;
    r_hs_s   = rvalid_q && rready;
    commit_s = aw_held_q && w_held_q;
    wr_en_s  = commit_s && (w_strb_q != 4'd0);

    // Address / data holding registers
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      aw_held_d = aw_held_q || aw_hs_s;
      w_held_d  = w_held_q || w_hs_s;
    end
    aw_idx_d = aw_hs_s ? awaddr[6:2] : aw_idx_q;
    w_data_d = w_hs_s ? wdata : w_data_q;
    w_strb_d = w_hs_s ? wstrb : w_strb_q;

    // Write response
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp_s;
    end else if (b_hs_s) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end else begin
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;

    // Read response
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word_s;
      rresp_d  = rd_resp_s;
    end else if (r_hs_s) begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end else begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
    end
    arready_d = !rvalid_d;

    // Writable operand registers
    key_d   = key_q;
    nonce_d = nonce_q;
    ad_d    = ad_q;
    din_d   = din_q;
    if (wr_en_s) begin
      case (aw_idx_q[4:2])
        3'd0: key_d[{aw_idx_q[1:0], 5'd0} +: 32] =
                byte_merge(word_of(key_q, aw_idx_q[1:0]), w_data_q, w_strb_q);
        3'd1: nonce_d[{aw_idx_q[1:0], 5'd0} +: 32] =
                byte_merge(word_of(nonce_q, aw_idx_q[1:0]), w_data_q, w_strb_q);
        3'd2: ad_d[{aw_idx_q[1:0], 5'd0} +: 32] =
                byte_merge(word_of(ad_q, aw_idx_q[1:0]), w_data_q, w_strb_q);
        3'd3: din_d[{aw_idx_q[1:0], 5'd0} +: 32] =
                byte_merge(word_of(din_q, aw_idx_q[1:0]), w_data_q, w_strb_q);
        default: key_d = key_q;
      endcase
    end else begin
      key_d = key_q;
    end

    // CONTROL lives in byte lane 0 only
    ctrl_wr_s = wr_en_s && (aw_idx_q == IDX_CONTROL) && w_strb_q[0];
    clr_end_s = ctrl_wr_s && w_data_q[0];
    if (ctrl_wr_s) begin
      start_d = w_data_q[0];
      mode_d  = w_data_q[1];
    end else begin
      start_d = start_q;
      mode_d  = mode_q;
    end

    // Block strobes follow the commit of the last word of a block
    ad_valid_d  = wr_en_s && (aw_idx_q == IDX_AD3);
    din_valid_d = wr_en_s && (aw_idx_q == IDX_DIN3);

    // Core results and sticky status; a set always wins over a clear
    dout_d = dout_valid ? dout : dout_q;
    tag_d  = tag_valid ? tag : tag_q;
    if (tag_valid) begin
      end_aead_d = 1'b1;
    end else if (clr_end_s) begin
      end_aead_d = 1'b0;
    end else begin
      end_aead_d = end_aead_q;
    end
    if (dout_valid) begin
      dout_avail_d = 1'b1;
    end else if (ar_hs_s && (ar_idx_s == IDX_DOUT3)) begin
      dout_avail_d = 1'b0;
    end else begin
      dout_avail_d = dout_avail_q;
    end
  end

  // State registers; reset drops any in-flight transaction silently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held_q    <= 1'b0;
      aw_idx_q     <= 5'd0;
      w_held_q     <= 1'b0;
      w_data_q     <= 32'd0;
      w_strb_q     <= 4'd0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      key_q        <= 128'd0;
      nonce_q      <= 128'd0;
      ad_q         <= 128'd0;
      din_q        <= 128'd0;
      dout_q       <= 128'd0;
      tag_q        <= 128'd0;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      end_aead_q   <= 1'b0;
      dout_avail_q <= 1'b0;
      ad_valid_q   <= 1'b0;
      din_valid_q  <= 1'b0;
    end else begin
      aw_held_q    <= aw_held_d;
      aw_idx_q     <= aw_idx_d;
      w_held_q     <= w_held_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ad_q         <= ad_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      tag_q        <= tag_d;
      start_q      <= start_d;
      mode_q       <= mode_d;
      end_aead_q   <= end_aead_d;
      dout_avail_q <= dout_avail_d;
      ad_valid_q   <= ad_valid_d;
      din_valid_q  <= din_valid_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign key       = key_q;
  assign nonce     = nonce_q;
  assign ad        = ad_q;
  assign din       = din_q;
  assign ad_valid  = ad_valid_q;
  assign din_valid = din_valid_q;
  assign start     = start_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_ascon_aead128_axi_slave.sv
// tb_ascon_aead128_axi_slave
// Self-checking bench: expected write/read responses are pushed to scoreboard
// queues when stimulus is issued and popped when the DUT answers.
// Honours ASCON_AXI_SLVERR_EN for the expected error responses.
`timescale 1ns/1ps
module tb_ascon_aead128_axi_slave;

`ifdef ASCON_AXI_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  localparam logic [1:0] OKAY = 2'b00;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [6:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] key, nonce, ad, din, dout, tag;
  logic         ad_valid, din_valid, start, mode;
  logic         dout_valid, tag_valid, core_ready;

  int n_checks = 0;
  int n_fail = 0;
  int ad_pulses = 0;
  int din_pulses = 0;

  exp_t       r_q[$];
  logic [1:0] b_q[$];

  logic [556:0] all_out;
  assign all_out = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                    key, nonce, ad, din, ad_valid, din_valid, start, mode};

  // Bench-side model of the result registers
  logic [127:0] dout_m;
  logic         dout_avail_m, end_aead_m;

  ascon_aead128_axi_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .key(key), .nonce(nonce), .ad(ad), .din(din),
    .ad_valid(ad_valid), .din_valid(din_valid), .start(start), .mode(mode),
    .dout(dout), .tag(tag), .dout_valid(dout_valid), .tag_valid(tag_valid),
    .core_ready(core_ready)
  );

  always #5 aclk = ~aclk;

  // Count strobe cycles, sampled mid-cycle
  always @(negedge aclk) begin
    if (ad_valid === 1'b1) ad_pulses++;
    if (din_valid === 1'b1) din_pulses++;
  end

  // Hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic send_aw(input logic [4:0] idx);
    int t = 0;
    @(negedge aclk);
    awaddr = {idx, 2'b00}; awvalid = 1'b1;
    while (awready !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    if (awready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout: awready=%b, required 1", awready);
    end
    @(posedge aclk); #1; awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    @(negedge aclk);
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (wready !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    if (wready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL w_timeout: wready=%b, required 1", wready);
    end
    @(posedge aclk); #1; wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [4:0] idx);
    int t = 0;
    @(negedge aclk);
    araddr = {idx, 2'b00}; arvalid = 1'b1;
    while (arready !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    if (arready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: arready=%b, required 1", arready);
    end
    @(posedge aclk); #1; arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic adv);
    int t = 0;
    while (bvalid !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    resp = bresp; adv = ad_valid;
    if (bvalid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL b_timeout: bvalid=%b, required 1", bvalid);
    end else begin
      bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
    end
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    while (rvalid !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    data = rdata; resp = rresp;
    if (rvalid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL r_timeout: rvalid=%b, required 1", rvalid);
    end else begin
      rready = 1'b1; @(posedge aclk); #1; rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic adv);
    fork
      send_aw(idx);
      send_w(data, strb);
    join
    wait_b(resp, adv);
  endtask

  task automatic do_read(input logic [4:0] idx, output logic [31:0] data,
                         output logic [1:0] resp);
    send_ar(idx);
    wait_r(data, resp);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required all zero", all_out);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_key_write();
    logic [1:0] gr, eb; logic ga; logic [31:0] gd; exp_t er;
    b_q.push_back(OKAY);
    do_write(5'd0, 32'hDEADBEEF, 4'hF, gr, ga);
    eb = b_q.pop_front(); n_checks++;
    if (gr !== eb) begin n_fail++; $display("FAIL key_bresp: got %b, required %b", gr, eb); end
    r_q.push_back({32'hDEADBEEF, OKAY});
    do_read(5'd0, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL key_read: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    n_checks++;
    if (key[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL key_port: got %h, required deadbeef", key[31:0]);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0] gr, eb; logic ga; logic [31:0] gd; exp_t er;
    b_q.push_back(OKAY);
    do_write(5'd0, 32'h11223344, 4'b0101, gr, ga);
    b_q.push_back(OKAY);
    do_write(5'd0, 32'h00000000, 4'b0000, gr, ga);
    eb = b_q.pop_front(); eb = b_q.pop_front(); n_checks++;
    if (gr !== eb) begin n_fail++; $display("FAIL strb0_bresp: got %b, required %b", gr, eb); end
    b_q.push_back(OKAY);
    do_write(5'd3, 32'hAB998877, 4'b1000, gr, ga);
    eb = b_q.pop_front();
    r_q.push_back({32'hDE22BE44, OKAY});
    do_read(5'd0, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL strb_merge: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    n_checks++;
    if (key[127:96] !== 32'hAB000000) begin
      n_fail++; $display("FAIL strb_lane3: got %h, required ab000000", key[127:96]);
    end
  endtask

  task automatic test_ad_strobe();
    logic [1:0] gr, eb; logic ga; int p0, q0;
    p0 = ad_pulses; q0 = din_pulses;
    for (int i = 0; i < 4; i++) begin
      b_q.push_back(OKAY);
      do_write(5'(8 + i), 32'(i + 1), 4'hF, gr, ga);
      eb = b_q.pop_front(); n_checks++;
      if (gr !== eb || ga !== (i == 3)) begin
        n_fail++; $display("FAIL ad_write%0d: resp %b strobe %b, required %b %b", i, gr, ga, eb, (i == 3));
      end
    end
    repeat (3) @(negedge aclk);
    n_checks++;
    if (ad !== 128'h00000004_00000003_00000002_00000001 || ad_pulses - p0 !== 1) begin
      n_fail++; $display("FAIL ad_block: got %h pulses %0d, required 00000004000000030000000200000001 pulses 1", ad, ad_pulses - p0);
    end
    for (int i = 0; i < 4; i++) begin
      b_q.push_back(OKAY);
      do_write(5'(12 + i), 32'hA0 + 32'(i), 4'hF, gr, ga);
      eb = b_q.pop_front();
    end
    repeat (3) @(negedge aclk);
    n_checks++;
    if (din !== 128'h000000A3_000000A2_000000A1_000000A0 || din_pulses - q0 !== 1 || ad_pulses - p0 !== 1) begin
      n_fail++; $display("FAIL din_block: got %h din_pulses %0d ad_pulses %0d, required 000000a3000000a2000000a1000000a0 1 1", din, din_pulses - q0, ad_pulses - p0);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] eb; int held; int t;
    b_q.push_back(OKAY);
    send_w(32'hA5A55A5A, 4'hF);
    send_aw(5'd1);
    t = 0;
    while (bvalid !== 1'b1 && t < 40) begin @(negedge aclk); t++; end
    held = 0;
    awaddr = {5'd2, 2'b00}; awvalid = 1'b1; wdata = 32'h12345678; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0) held++;
      @(negedge aclk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    eb = b_q.pop_front(); n_checks++;
    if (held !== 3 || bresp !== eb) begin
      n_fail++; $display("FAIL wb_hold: held %0d resp %b, required 3 %b", held, bresp, eb);
    end
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++;
    if (key[63:32] !== 32'hA5A55A5A || key[95:64] !== 32'h0 || bvalid !== 1'b0 || awready !== 1'b1) begin
      n_fail++; $display("FAIL wb_commit: key1 %h key2 %h bvalid %b awready %b, required a5a55a5a 00000000 0 1", key[63:32], key[95:64], bvalid, awready);
    end
  endtask

  task automatic test_dout_status();
    logic [127:0] d2; logic [1:0] gr; logic [31:0] gd; exp_t er;
    @(negedge aclk);
    dout = 128'h01234567_89ABCDEF_FEDCBA98_765432EF; dout_valid = 1'b1;
    @(negedge aclk);
    dout_valid = 1'b0; dout_m = dout; dout_avail_m = 1'b1;
    r_q.push_back({{29'd0, dout_avail_m, end_aead_m, 1'b1}, OKAY});
    do_read(5'd25, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL status_set: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    for (int i = 0; i < 4; i++) begin
      r_q.push_back({dout_m[32*i +: 32], OKAY});
      do_read(5'(16 + i), gd, gr);
      er = r_q.pop_front(); n_checks++;
      if ({gd, gr} !== er) begin
        n_fail++; $display("FAIL dout_word%0d: got %h/%b, required %h/%b", i, gd, gr, er.data, er.resp);
      end
    end
    dout_avail_m = 1'b0;
    r_q.push_back({{29'd0, dout_avail_m, end_aead_m, 1'b1}, OKAY});
    do_read(5'd25, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL status_clr: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    // DOUT read in the same cycle as a new result returns the old result
    d2 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    r_q.push_back({dout_m[63:32], OKAY});
    @(negedge aclk);
    araddr = {5'd17, 2'b00}; arvalid = 1'b1; dout = d2; dout_valid = 1'b1;
    n_checks++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL race_arready: got %b, required 1", arready); end
    @(posedge aclk); #1; arvalid = 1'b0; dout_valid = 1'b0;
    dout_m = d2; dout_avail_m = 1'b1;
    wait_r(gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL dout_race_old: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    r_q.push_back({dout_m[63:32], OKAY});
    do_read(5'd17, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL dout_race_new: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
  endtask

  task automatic test_tag_control();
    logic [127:0] tv; logic [1:0] gr, eb; logic ga; logic [31:0] gd; exp_t er;
    tv = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    @(negedge aclk); tag = tv; tag_valid = 1'b1;
    @(negedge aclk); tag_valid = 1'b0; end_aead_m = 1'b1; core_ready = 1'b0;
    r_q.push_back({{29'd0, dout_avail_m, end_aead_m, 1'b0}, OKAY});
    do_read(5'd25, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL status_tag: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    core_ready = 1'b1;
    r_q.push_back({tv[95:64], OKAY});
    do_read(5'd22, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL tag_word2: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    b_q.push_back(OKAY);
    do_write(5'd24, 32'h00000003, 4'hF, gr, ga);
    eb = b_q.pop_front(); end_aead_m = 1'b0;
    n_checks++;
    if (gr !== eb || start !== 1'b1 || mode !== 1'b1) begin
      n_fail++; $display("FAIL control_write: resp %b start %b mode %b, required %b 1 1", gr, start, mode, eb);
    end
    r_q.push_back({{29'd0, dout_avail_m, end_aead_m, 1'b1}, OKAY});
    do_read(5'd25, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL status_start_clr: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    // tag_valid in the commit cycle of a start=1 write keeps end_aead set
    b_q.push_back(OKAY);
    fork
      send_aw(5'd24);
      send_w(32'h00000001, 4'hF);
    join
    @(negedge aclk); tag_valid = 1'b1;
    @(posedge aclk); #1; tag_valid = 1'b0;
    wait_b(gr, ga);
    eb = b_q.pop_front(); end_aead_m = 1'b1;
    r_q.push_back({{29'd0, dout_avail_m, end_aead_m, 1'b1}, OKAY});
    do_read(5'd25, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL status_set_wins: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    r_q.push_back({32'h00000001, OKAY});
    do_read(5'd24, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL control_read: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
  endtask

  task automatic test_readonly_unmapped();
    logic [1:0] gr, eb; logic ga; logic [31:0] gd; exp_t er;
    logic [4:0] widx [3];
    widx[0] = 5'd16; widx[1] = 5'd25; widx[2] = 5'd30;
    for (int i = 0; i < 3; i++) begin
      b_q.push_back(ERR);
      do_write(widx[i], 32'hFFFFFFFF, 4'hF, gr, ga);
      eb = b_q.pop_front(); n_checks++;
      if (gr !== eb) begin
        n_fail++; $display("FAIL ro_bresp_idx%0d: got %b, required %b", widx[i], gr, eb);
      end
    end
    r_q.push_back({dout_m[31:0], OKAY});
    do_read(5'd16, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL dout_unchanged: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    r_q.push_back({32'h00000000, ERR});
    do_read(5'd30, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL unmapped_read: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] gr, eb; logic ga; logic [31:0] gd; exp_t er;
    b_q.push_back(OKAY);
    r_q.push_back({32'h00000000, OKAY});
    fork
      send_aw(5'd5);
      send_w(32'hC0FFEE11, 4'hF);
    join
    send_ar(5'd5);
    wait_b(gr, ga);
    eb = b_q.pop_front(); n_checks++;
    if (gr !== eb) begin n_fail++; $display("FAIL b2b_bresp: got %b, required %b", gr, eb); end
    wait_r(gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er) begin
      n_fail++; $display("FAIL b2b_prewrite: got %h/%b, required %h/%b", gd, gr, er.data, er.resp);
    end
    r_q.push_back({32'hC0FFEE11, OKAY});
    do_read(5'd5, gd, gr);
    er = r_q.pop_front(); n_checks++;
    if ({gd, gr} !== er || nonce[63:32] !== 32'hC0FFEE11) begin
      n_fail++; $display("FAIL b2b_postwrite: got %h/%b nonce1 %h, required %h/%b", gd, gr, nonce[63:32], er.data, er.resp);
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen_b;
    send_aw(5'd2);
    @(negedge aclk); aresetn = 1'b0; #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h, required all zero", all_out);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    n_checks++;
    if (awready !== 1'b0 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_release: awready %b bvalid %b, required 0 0", awready, bvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL midreset_ready: got %b, required 111", {awready, wready, arready});
    end
    seen_b = 1'b0;
    repeat (4) begin @(negedge aclk); if (bvalid !== 1'b0) seen_b = 1'b1; end
    n_checks++;
    if (seen_b !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_resp: bvalid seen %b, required 0", seen_b);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = 7'd0; awprot = 3'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;
    araddr = 7'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
    dout = 128'd0; tag = 128'd0; dout_valid = 1'b0; tag_valid = 1'b0;
    core_ready = 1'b1;
    dout_m = 128'd0; dout_avail_m = 1'b0; end_aead_m = 1'b0;

    test_reset();
    test_key_write();
    test_wstrb();
    test_ad_strobe();
    test_w_before_aw();
    test_dout_status();
    test_tag_control();
    test_readonly_unmapped();
    test_back_to_back();
    test_reset_mid_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
